// File: rtl/mult_pkg.sv
// +------------------------------------------------------------------+
// | mult_pkg : shared types and sizes for the shift-and-add multiplier |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    localparam int MULT_W     = 16;
    localparam int MULT_CNT_W = $clog2(MULT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_shift_add_dp.sv
// +------------------------------------------------------------------+
// | mult_shift_add_dp : multiplicand/multiplier/accumulator datapath  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] acc_next,
    output logic           mplier_next_zero
);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;

    always_comb begin
        acc_next         = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_next_zero = ((mplier_q >> 1) == '0);
        mcand_d          = mcand_q;
        mplier_d         = mplier_q;
        acc_d            = acc_q;
        if (load) begin
            mcand_d  = {{W{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_shift_add.sv
// +------------------------------------------------------------------+
// | mult_shift_add : sequential unsigned WxW shift-and-add multiplier |
// | Option macro MULT_SHIFT_ADD_EARLY_EXIT_EN: stop once no multiplier |
// | bits remain. Rev 1.0                                             |
// +------------------------------------------------------------------+
`default_nettype none

module mult_shift_add
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    input  logic [W-1:0]   op_A,
    input  logic [W-1:0]   op_B,
    output logic [2*W-1:0] result,
    output logic           done
);

    localparam int CNT_W = $clog2(W);

    mult_state_t    state_q, state_d;
    logic           init_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] result_q, result_d;
    logic           done_q, done_d;

    logic           start;
    logic           load;
    logic           step;
    logic           last_iter;
    logic           finish;
    logic [2*W-1:0] acc_next;
    logic           mplier_next_zero;

    assign start = init & ~init_q;

    mult_shift_add_dp #(
        .W (W)
    ) u_dp (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .step             (step),
        .op_a             (op_A),
        .op_b             (op_B),
        .acc_next         (acc_next),
        .mplier_next_zero (mplier_next_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= init;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // A start edge always wins, including in RUN where it aborts the current product.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (start)          state_d = RUN;
                else if (last_iter) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MULT_SHIFT_ADD_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_W'(W - 1)) | mplier_next_zero;
`else
    logic mplier_next_zero_unused;
    assign mplier_next_zero_unused = mplier_next_zero;
    assign last_iter = (cnt_q == CNT_W'(W - 1));
`endif

    always_comb begin
        load     = start;
        step     = (state_q == RUN) & ~start;
        finish   = step & last_iter;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        if (load) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (finish) begin
                result_d = acc_next;
                done_d   = 1'b1;
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_shift_add.sv
// +------------------------------------------------------------------+
// | tb_mult_shift_add : self-checking bench for mult_shift_add        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mult_shift_add;

    logic        clk;
    logic        reset;
    logic        init;
    logic [15:0] op_A;
    logic [15:0] op_B;
    logic [31:0] result;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    mult_shift_add #(.W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .op_A   (op_A),
        .op_B   (op_B),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: product from plain arithmetic, latency from the operand's bit length.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p;
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
`ifdef MULT_SHIFT_ADD_EARLY_EXIT_EN
        int k;
        k = 1;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return k;
`else
        return 16;
`endif
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after E0 until done rises; bounded.
    task automatic await_done(input int exp_lat, input string tag);
        int n;
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if (done === 1'b1) break;
        end
        chk(32'(n), 32'(exp_lat), {tag, "_latency"});
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        init = 1'b0;
        tick();
        op_A = a;
        op_B = b;
        init = 1'b1;
        tick();
        chk(32'(done), 32'd0, {tag, "_done_low_at_E0"});
        await_done(ref_lat(b), tag);
        chk(result, ref_prod(a, b), {tag, "_result"});
    endtask

    initial begin
        logic [15:0] ra, rb;
        reset = 1'b1;
        init  = 1'b0;
        op_A  = '0;
        op_B  = '0;
        #12;
        chk(result, 32'h0, "reset_result");
        chk(32'(done), 32'd0, "reset_done");
        #3;
        reset = 1'b0;
        tick();

        run_op(16'd3, 16'd5, "mul_3x5");
        chk(result, 32'h0000_000F, "mul_3x5_const");

        run_op(16'hFFFF, 16'hFFFF, "mul_max");
        chk(result, 32'hFFFE_0001, "mul_max_const");
        repeat (40) tick();
        chk(32'(done), 32'd1, "hold_init_done");
        chk(result, 32'hFFFE_0001, "hold_init_result");

        // Abort: restart mid-run with a new multiplier.
        init = 1'b0;
        tick();
        op_A = 16'h1234;
        op_B = 16'h0010;
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
        tick();
        init = 1'b1;
        op_B = 16'h0002;
        tick();
        chk(32'(done), 32'd0, "abort_done_low");
        await_done(ref_lat(16'h0002), "abort");
        chk(result, 32'h0000_2468, "abort_result");

        // Operand change after the start edge is ignored.
        init = 1'b0;
        tick();
        op_A = 16'd7;
        op_B = 16'd6;
        init = 1'b1;
        tick();
        tick();
        tick();
        op_A = 16'd9;
        op_B = 16'hFFFF;
        await_done(ref_lat(16'd6) - 2, "opchg");
        chk(result, 32'd42, "opchg_result");

        run_op(16'hABCD, 16'h0001, "b_one");
        run_op(16'h5555, 16'h0000, "b_zero");
        run_op(16'h0002, 16'h8000, "b_msb");
        chk(result, 32'h0001_0000, "b_msb_const");

        // Asynchronous reset mid-run.
        init = 1'b0;
        tick();
        op_A = 16'h1111;
        op_B = 16'h8001;
        init = 1'b1;
        tick();
        repeat (8) tick();
        #2;
        reset = 1'b1;
        #1;
        chk(result, 32'h0, "async_reset_result");
        chk(32'(done), 32'd0, "async_reset_done");
        init = 1'b0;
        #2;
        reset = 1'b0;
        repeat (20) tick();
        chk(result, 32'h0, "post_reset_idle_result");
        chk(32'(done), 32'd0, "post_reset_idle_done");

        // init already high when reset releases: first edge is the start edge.
        run_op(16'h0F0F, 16'h00F3, "pre_reset");
        #2;
        reset = 1'b1;
        op_A  = 16'h00FF;
        op_B  = 16'h0101;
        init  = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        chk(32'(done), 32'd0, "init_high_E0_done");
        await_done(ref_lat(16'h0101), "init_high");
        chk(result, ref_prod(16'h00FF, 16'h0101), "init_high_result");

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 1) rb = rb >> (i % 16);
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
